decode_execute_reg: RTL
=======================

DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.
- CTRL_W, 12, width of the opaque execute-stage control bundle.
- CNT_W, 16, width of the performance counters.
- USE_HAZARD, 1, enables load-use detection (0 = detection disabled).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- valid_d  in  1  decode-stage instruction valid.
- rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d  in  XLEN  decode-stage operands.
- rs1_d, rs2_d, rd_d  in  RA_W  source and destination register indices.
- ctrl_d  in  CTRL_W  decoded control bundle.
- mem_read_d  in  1  instruction is a load.
- stall_e  in  1  hold the execute register (downstream back-pressure).
- flush_e  in  1  kill the instruction entering execute (taken branch or jump).
- valid_e, rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e, rs1_e, rs2_e, rd_e, ctrl_e, mem_read_e  out  (matching widths)  registered execute-stage copies.
- load_use_stall  out  1  combinational request to freeze fetch and decode.
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.
- flush_cnt  out  CNT_W  count of flush cycles.

Function
REQ-004 All outputs except load_use_stall SHALL be registered and update only on the rising edge of clk.
REQ-005 load_use_stall SHALL be high exactly when USE_HAZARD=1, valid_e=1, mem_read_e=1, rd_e!=0, valid_d=1, flush_e=0, stall_e=0, and rd_e equals rs1_d or rs2_d.
REQ-006 With USE_HAZARD=0, load_use_stall SHALL be constant 0 and bubble_cnt SHALL stay 0.
REQ-007 Each edge, the block SHALL take exactly one action, chosen in this priority order: reset, flush, hold, bubble, load.
REQ-008 Flush (flush_e=1): all execute-stage outputs SHALL become 0, including valid_e, ctrl_e, mem_read_e and rd_e. Flush SHALL override a simultaneous stall_e or hazard.
REQ-009 Hold (stall_e=1, flush_e=0): every execute-stage output SHALL retain its value.
REQ-010 Bubble (load_use_stall=1): all execute-stage outputs SHALL become 0, as for flush.
REQ-011 Load (otherwise): every *_e output SHALL capture its *_d input, and valid_e SHALL capture valid_d.
REQ-012 A bubble SHALL last exactly one cycle: on the next edge mem_read_e=0, so load_use_stall deasserts and the held decode instruction loads.
REQ-013 Writes to register 0 (rd_e=0) SHALL never raise load_use_stall.
REQ-014 bubble_cnt SHALL increment by 1 on each edge where a bubble is inserted.
REQ-015 flush_cnt SHALL increment by 1 on each edge where flush_e=1.
REQ-016 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 Counters SHALL not change on hold edges, nor on edges where neither their event nor reset occurs.
REQ-018 The block SHALL contain no latches and no combinational path from stall_e to any registered output.

Reset
REQ-019 When rst_n=0 at a rising edge, every registered output SHALL become 0, including both counters.
REQ-020 Reset SHALL take priority over flush_e, stall_e and the hazard condition.
REQ-021 Reset asserted mid-stall or mid-bubble SHALL discard the in-flight instruction: valid_e=0 on the following cycle.
REQ-022 On the first edge with rst_n=1, normal load behaviour SHALL resume.

Verification
REQ-023 Plain load: valid_d=1, rd1_d=0x0000_00AA, rd_d=7, no stall or flush -> one edge later valid_e=1, rd1_e=0x0000_00AA, rd_e=7.
REQ-024 Load-use: execute holds a load with rd_e=5, and decode presents rs2_d=5 -> load_use_stall=1 that cycle; next edge valid_e=0 and bubble_cnt=1; following edge the decode instruction appears with valid_e=1.
REQ-025 No false hazard: a load with rd_e=0 and rs1_d=0 -> load_use_stall=0 and no bubble.
REQ-026 Priority: flush_e=1 together with stall_e=1 and a hazard -> next edge valid_e=0 and flush_cnt increments while bubble_cnt does not; stall_e=1 alone for 3 cycles -> all *_e outputs unchanged for those 3 cycles.
REQ-027 Saturation: with CNT_W=4, apply 20 flush cycles -> flush_cnt reads 15 and stays at 15.
REQ-028 Reset mid-operation: with valid_e=1 and stall_e=1, drive rst_n=0 for one edge -> all registered outputs 0; on the next edge with rst_n=1, valid_d loads normally.

Source files
------------

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// flush handling and saturating bubble/flush event counters.
module decode_execute_reg #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int CTRL_W     = 12,
  parameter int CNT_W      = 16,
  parameter bit USE_HAZARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   imm_ext_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic [RA_W-1:0]   rs1_d,
  input  logic [RA_W-1:0]   rs2_d,
  input  logic [RA_W-1:0]   rd_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              mem_read_d,
  input  logic              stall_e,
  input  logic              flush_e,
  output logic              valid_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [RA_W-1:0]   rs1_e,
  output logic [RA_W-1:0]   rs2_e,
  output logic [RA_W-1:0]   rd_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic              mem_read_e,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic src_hit;
  logic clear_e;

  assign src_hit = (rd_e == rs1_d) || (rd_e == rs2_d);

  generate
    if (USE_HAZARD) begin : g_hz
      assign load_use_stall = valid_e && mem_read_e
                           && (rd_e != '0) && valid_d
                           && !flush_e && !stall_e
                           && src_hit;
    end else begin : g_no_hz
      assign load_use_stall = 1'b0;
    end
  endgenerate

  // Reset, flush and bubble all zero the execute stage
  assign clear_e = !rst_n || flush_e
                || (!stall_e && load_use_stall);

  always_ff @(posedge clk) begin
    if (clear_e) begin
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      pc_e       <= '0;
      imm_ext_e  <= '0;
      pc_plus4_e <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      ctrl_e     <= '0;
      mem_read_e <= 1'b0;
    end else if (!stall_e) begin
      valid_e    <= valid_d;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      pc_e       <= pc_d;
      imm_ext_e  <= imm_ext_d;
      pc_plus4_e <= pc_plus4_d;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= rd_d;
      ctrl_e     <= ctrl_d;
      mem_read_e <= mem_read_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (flush_e && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (load_use_stall && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
